// File: rtl/cdec8_dbg_monitor.sv
// CDEC8 debug-monitor host port: UART command in, resad drive, resdt capture, UART reply out.
// Command DUMP_CMD returns resources 0x00-0x0F back to back.
module cdec8_dbg_monitor #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  DUMP_CMD     = 8'hFF
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] resad,
  input  logic [7:0] resdt,
  output logic       busy,
  output logic       frame_err,
  output logic       ovr_err
);

  localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {StIdle, StSetup, StCapture, StTxLoad, StTxWait, StNext} main_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;

  main_state_e     main_q, main_d;
  logic [7:0]      resad_q, resad_d;
  logic            busy_q, busy_d;
  logic            dump_q, dump_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            ovr_err_q, ovr_err_d;
  logic            tx_start;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            txd_q, txd_d;
  logic            tx_done;

  // Receiver: start re-checked at mid-bit, then one sample per bit period
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfCnt) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == CntMax) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == CntMax) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
          if (rx_s2_q) rx_valid_d  = 1'b1;
          else         frame_err_d = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    main_d    = main_q;
    resad_d   = resad_q;
    busy_d    = busy_q;
    dump_d    = dump_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;
    ovr_err_d = rx_valid_q && busy_q;
    case (main_q)
      StIdle: begin
        if (rx_valid_q) begin
          busy_d = 1'b1;
          main_d = StSetup;
          if (rx_shift_q == DUMP_CMD) begin
            resad_d = 8'h00;
            dump_d  = 1'b1;
          end else begin
            resad_d = rx_shift_q;
          end
        end
      end
      StSetup:   main_d = StCapture;
      StCapture: begin
        tx_data_d = resdt;
        main_d    = StTxLoad;
      end
      StTxLoad: begin
        tx_start = 1'b1;
        main_d   = StTxWait;
      end
      StTxWait: begin
        if (tx_done) begin
          if (dump_q && (resad_q != 8'h0F)) begin
            main_d = StNext;
          end else begin
            busy_d = 1'b0;
            dump_d = 1'b0;
            main_d = StIdle;
          end
        end
      end
      StNext: begin
        resad_d = resad_q + 8'h01;
        main_d  = StSetup;
      end
      default: main_d = StIdle;
    endcase
  end

  assign tx_done = (tx_state_q == TxStop) && (tx_cnt_q == CntMax);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TxIdle: begin
        txd_d = 1'b1;
        if (tx_start) begin
          tx_state_d = TxStart;
          tx_cnt_d   = '0;
          tx_shift_d = tx_data_q;
          txd_d      = 1'b0;
        end
      end
      TxStart: begin
        if (tx_cnt_q == CntMax) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == CntMax) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TxStop;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == CntMax) begin
          tx_state_d = TxIdle;
          tx_cnt_d   = '0;
          txd_d      = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_N) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      main_q      <= StIdle;
      resad_q     <= 8'h00;
      busy_q      <= 1'b0;
      dump_q      <= 1'b0;
      tx_data_q   <= '0;
      ovr_err_q   <= 1'b0;
      tx_state_q  <= TxIdle;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      txd_q       <= 1'b1;
    end else begin
      rx_s1_q     <= rxd;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      main_q      <= main_d;
      resad_q     <= resad_d;
      busy_q      <= busy_d;
      dump_q      <= dump_d;
      tx_data_q   <= tx_data_d;
      ovr_err_q   <= ovr_err_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      txd_q       <= txd_d;
    end
  end

  assign txd       = txd_q;
  assign resad     = resad_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign ovr_err   = ovr_err_q;

endmodule

// File: tb/tb_cdec8_dbg_monitor.sv
// Directed bench for cdec8_dbg_monitor; a passive monitor decodes txd frames into a queue.
module tb_cdec8_dbg_monitor;

  localparam int CPB = 8;

  logic       clock, reset_N, rxd, txd, busy, frame_err, ovr_err;
  logic [7:0] resad, resdt;

  int errors = 0;
  int checks = 0;

  cdec8_dbg_monitor #(
    .CLKS_PER_BIT(CPB),
    .DUMP_CMD    (8'hFF)
  ) dut (
    .clock    (clock),
    .reset_N  (reset_N),
    .rxd      (rxd),
    .txd      (txd),
    .resad    (resad),
    .resdt    (resdt),
    .busy     (busy),
    .frame_err(frame_err),
    .ovr_err  (ovr_err)
  );

  // Datapath stand-in
  assign resdt = resad ^ 8'hA5;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor state, sampled 1 time unit after each rising edge
  int         cyc = 0;
  int         resad_chg_cyc = 0;
  int         last_stop_cyc = 0;
  logic [7:0] resad_prev = 8'h00;
  int         fe_cnt = 0, ovr_cnt = 0, fmt_err = 0, busy_drop = 0;
  bit         mon_busy = 1'b0;
  int         mon_cnt = 0;
  int         k;
  logic [7:0] mon_sh;
  logic [7:0] frame_q[$];
  int         gap_q[$];
  int         lat_q[$];

  always begin
    @(posedge clock);
    #1;
    cyc++;
    if (frame_err === 1'b1) fe_cnt++;
    if (ovr_err === 1'b1) ovr_cnt++;
    if (resad !== resad_prev) begin
      resad_prev    = resad;
      resad_chg_cyc = cyc;
    end
    if (reset_N !== 1'b1) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        gap_q.push_back(cyc - last_stop_cyc - 1);
        lat_q.push_back(cyc - resad_chg_cyc);
      end
    end else begin
      mon_cnt++;
      if (busy !== 1'b1) busy_drop++;
      if (mon_cnt % CPB == CPB / 2) begin
        k = mon_cnt / CPB;
        if (k == 0) begin
          if (txd !== 1'b0) fmt_err++;
        end else if (k <= 8) begin
          mon_sh[k-1] = txd;
        end else begin
          if (txd !== 1'b1) fmt_err++;
          frame_q.push_back(mon_sh);
        end
      end
      if (mon_cnt == 10 * CPB - 1) begin
        mon_busy      = 1'b0;
        last_stop_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (CPB) @(negedge clock);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, (n < budget), 1);
    repeat (4) @(negedge clock);
  endtask

  task automatic clear_mon();
    frame_q.delete();
    gap_q.delete();
    lat_q.delete();
    fe_cnt    = 0;
    ovr_cnt   = 0;
    busy_drop = 0;
  endtask

  initial begin
    int n;
    rxd     = 1'b1;
    reset_N = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_txd", txd, 1);
    chk("rst_resad", resad, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_ovr_err", ovr_err, 0);
    reset_N = 1'b1;
    repeat (5) @(negedge clock);
    clear_mon();

    // Single read of resource 0x08
    chk("t1_txd_before", txd, 1);
    uart_send(8'h08, 1'b1);
    chk("t1_busy_on", busy, 1);
    chk("t1_resad", resad, 8'h08);
    wait_idle(200, "t1_timeout");
    chk("t1_nframes", frame_q.size(), 1);
    if (frame_q.size() >= 1) chk("t1_data", frame_q[0], 8'hAD);
    if (lat_q.size() >= 1) chk("t1_latency", lat_q[0], 3);
    chk("t1_busy_held", busy_drop, 0);
    chk("t1_busy_off", busy, 0);
    chk("t1_txd_after", txd, 1);

    // Full dump
    clear_mon();
    uart_send(8'hFF, 1'b1);
    wait_idle(2000, "t2_timeout");
    chk("t2_nframes", frame_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < frame_q.size()) chk($sformatf("t2_data%0d", i), frame_q[i], 8'(i) ^ 8'hA5);
      if (i < lat_q.size()) chk($sformatf("t2_lat%0d", i), lat_q[i], 3);
      if (i > 0 && i < gap_q.size()) chk($sformatf("t2_gap%0d", i), gap_q[i], 4);
    end
    chk("t2_resad", resad, 8'h0F);
    chk("t2_busy_held", busy_drop, 0);

    // Framing error
    clear_mon();
    uart_send(8'h03, 1'b0);
    repeat (20) @(negedge clock);
    chk("t3_frame_err", fe_cnt, 1);
    chk("t3_nframes", frame_q.size(), 0);
    chk("t3_resad", resad, 8'h0F);
    chk("t3_busy", busy, 0);

    // Overrun: second command lands during the reply
    clear_mon();
    uart_send(8'h01, 1'b1);
    uart_send(8'h02, 1'b1);
    wait_idle(300, "t4_timeout");
    repeat (20) @(negedge clock);
    chk("t4_ovr_err", ovr_cnt, 1);
    chk("t4_nframes", frame_q.size(), 1);
    if (frame_q.size() >= 1) chk("t4_data", frame_q[0], 8'hA4);
    chk("t4_resad", resad, 8'h01);
    chk("t4_frame_err", fe_cnt, 0);
    chk("t4_busy", busy, 0);

    // Short low glitch on rxd
    clear_mon();
    rxd = 1'b0;
    repeat (3) @(negedge clock);
    rxd = 1'b1;
    repeat (40) @(negedge clock);
    chk("t5_nframes", frame_q.size(), 0);
    chk("t5_frame_err", fe_cnt, 0);
    chk("t5_busy", busy, 0);
    chk("t5_txd", txd, 1);
    chk("t5_resad", resad, 8'h01);

    // Reset during the 5th data bit of a reply
    clear_mon();
    uart_send(8'h05, 1'b1);
    n = 0;
    while (txd !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("t6_start_seen", (n < 50), 1);
    repeat (44) @(negedge clock);
    reset_N = 1'b0;
    @(negedge clock);
    chk("t6_rst_txd", txd, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_resad", resad, 8'h00);
    reset_N = 1'b1;
    repeat (5) @(negedge clock);
    clear_mon();
    uart_send(8'h0A, 1'b1);
    wait_idle(200, "t6_timeout");
    chk("t6_nframes", frame_q.size(), 1);
    if (frame_q.size() >= 1) chk("t6_data", frame_q[0], 8'hAF);
    if (lat_q.size() >= 1) chk("t6_latency", lat_q[0], 3);
    chk("t6_resad", resad, 8'h0A);

    chk("frame_format", fmt_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdec8_dbg_monitor.md
Name: cdec8_dbg_monitor

Overview:
Host-side end of the CDEC8 datapath debug-monitor port, for the DE0 board. Receives one-byte commands from the PC over a UART (8N1), drives the datapath resource address (resad), samples the returned resource data (resdt) and transmits it back to the PC. Also supports a dump command that returns resources 0x00-0x0F in sequence. Sits in the top level between the board UART pins and the datapath resad/resdt pins.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
DUMP_CMD, 8'hFF, command byte that triggers a full dump of resources 0x00-0x0F.

Ports:
clock  in  1  system clock
reset_N  in  1  synchronous reset, active-low
rxd  in  1  UART receive line from PC, asynchronous, idle high
txd  out  1  UART transmit line to PC, idle high
resad  out  8  resource address to datapath debug port
resdt  in  8  resource data from datapath, valid one cycle after resad is stable
busy  out  1  high while a command is being serviced
frame_err  out  1  one-cycle pulse: received byte had stop bit = 0
ovr_err  out  1  one-cycle pulse: command byte dropped because busy

Behaviour:
- Reset (reset_N = 0 at a clock edge) sets: txd = 1, resad = 8'h00, busy = 0, frame_err = 0, ovr_err = 0, all FSMs to idle, all counters to 0. Reset mid-frame aborts the frame; txd returns to 1 on the next edge.
- RX synchronisation: rxd passes through a 2-flop synchroniser (reset value 1) before any use.
- RX FSM states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - Falling edge of the synchronised rxd in RX_IDLE enters RX_START.
  - At CLKS_PER_BIT/2 the line is re-sampled; if it is 1, the start is treated as a glitch and the FSM returns to RX_IDLE.
  - Data bits are sampled LSB first, every CLKS_PER_BIT cycles after the mid-start sample.
  - Stop bit sampled at mid-bit. Stop = 1 produces a one-cycle rx_valid with the byte; stop = 0 pulses frame_err and discards the byte.
  - The FSM then returns to RX_IDLE. The receiver runs regardless of busy.
- Main FSM states IDLE, SETUP, CAPTURE, TX_LOAD, TX_WAIT, NEXT:
  - IDLE: on rx_valid, set busy = 1. For a byte other than DUMP_CMD, resad = byte and go to SETUP. For DUMP_CMD, resad = 8'h00, set the dump flag, go to SETUP.
  - SETUP: one settle cycle, resad held.
  - CAPTURE: latch resdt into the tx data register.
  - TX_LOAD: start the transmitter.
  - TX_WAIT: wait for tx_done.
  - Then, if the dump flag is set and resad != 8'h0F, go to NEXT; otherwise clear busy and the dump flag and go to IDLE.
  - NEXT: resad = resad + 1, then SETUP.
- Timing: resad updates on the edge after rx_valid. resdt is sampled exactly two edges after resad changes. The start bit begins one cycle after the sample.
- rx_valid while busy = 1 is dropped and pulses ovr_err; the state of the current command is unaffected.
- resad holds its last value in IDLE; it is never cleared except by reset.
- Non-dump addresses 0x10-0xFE are passed through unchanged. The returned data is whatever the top level drives on resdt (typically 8'hFF or Z for unmapped addresses); the monitor does not filter.
- TX:
  - 8N1 frame, LSB first. Start bit 0, 8 data bits, stop bit 1, each exactly CLKS_PER_BIT cycles. Frame is 10*CLKS_PER_BIT cycles.
  - tx_done pulses on the last cycle of the stop bit. txd = 1 between frames.
  - Dump: 16 back-to-back frames, with exactly 4 idle cycles (NEXT, SETUP, CAPTURE, TX_LOAD) between consecutive stop and start bits.
- The bit counter wraps at CLKS_PER_BIT-1. The resad increment is 8-bit; the dump stops at 0x0F, so no wrap occurs.

Test Plan (CLKS_PER_BIT = 8, datapath model returns resdt = resad ^ 8'hA5 combinationally):
- Reset, then send byte 0x08 -> resad = 0x08 one cycle after rx_valid; one frame is transmitted with data 0xAD; busy is high for the whole service and low afterwards; txd = 1 before and after.
- Send 0xFF -> 16 frames carrying 0xA5, 0xA4, ... 0xAA (resad 0x00-0x0F); inter-frame gap is 4 cycles; final resad = 0x0F.
- Send 0x03 with stop bit forced to 0 -> frame_err pulses once; no transmission; resad unchanged.
- Send 0x01, then send 0x02 during the reply -> ovr_err pulses once; only one frame (0xA4) is transmitted.
- 3-cycle low glitch on rxd -> no rx_valid, no frame_err, txd stays 1.
- Assert reset_N low during the 5th data bit of a transmit -> next edge gives txd = 1, busy = 0, resad = 0x00; a following command 0x0A returns 0xAF normally.
